// File: rtl/seq_pkg.sv
// Shared types and default widths for the program-counter sequencer.
// The sequencer FSM states and the branch-condition encoding seen on br_cond.
package seq_pkg;

    localparam int unsigned PC_W_DEF  = 10;
    localparam int unsigned CYC_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        RUN   = 2'b10,
        HALT  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        BR_ALWAYS = 2'b00,
        BR_ZERO   = 2'b01,
        BR_NZERO  = 2'b10,
        BR_NEVER  = 2'b11
    } br_cond_e;

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational branch resolver: decides whether the branch is taken against Zero
// and produces the following pc (branch target or pc + 1, both modulo 2^PC_W).
module next_pc_calc
    import seq_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0] pc,
    input  logic            br_en,
    input  br_cond_e        br_cond,
    input  logic            br_rel,
    input  logic [PC_W-1:0] br_offset,
    input  logic [PC_W-1:0] br_target,
    input  logic            zero,
    output logic            taken,
    output logic [PC_W-1:0] next_pc
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic            cond_ok;
    logic [PC_W-1:0] target;

    always_comb begin
        cond_ok = 1'b0;
        unique case (br_cond)
            BR_ALWAYS: cond_ok = 1'b1;
            BR_ZERO:   cond_ok = zero;
            BR_NZERO:  cond_ok = !zero;
            default:   cond_ok = 1'b0;
        endcase
        taken = br_en && cond_ok;
        // Two's-complement add at PC_W bits gives the wrapping signed offset for free.
        target  = br_rel ? (pc + br_offset) : br_target;
        next_pc = taken ? target : (pc + PC_ONE);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and run/halt control: arms on start, runs until Done_in,
// resolves branches against Zero_in and counts RUN cycles with saturation.
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter int unsigned     CYC_W    = CYC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              Zero_in,
    input  logic              Done_in,
    input  logic              br_en,
    input  logic [1:0]        br_cond,
    input  logic              br_rel,
    input  logic [PC_W-1:0]   br_offset,
    input  logic [PC_W-1:0]   br_target,
    output logic [PC_W-1:0]   pc,
    output logic              fetch_en,
    output logic              done,
    output logic [CYC_W-1:0]  cycle_count
);

    localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             br_taken;
    logic [PC_W-1:0]  next_pc;

    next_pc_calc #(
        .PC_W(PC_W)
    ) u_next_pc (
        .pc        (pc_q),
        .br_en     (br_en),
        .br_cond   (br_cond_e'(br_cond)),
        .br_rel    (br_rel),
        .br_offset (br_offset),
        .br_target (br_target),
        .zero      (Zero_in),
        .taken     (br_taken),
        .next_pc   (next_pc)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cyc_q   <= cyc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cyc_d   = cyc_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = ARMED;
            end
            ARMED: begin
                pc_d  = RESET_PC;
                cyc_d = '0;
                if (!start) state_d = RUN;
            end
            RUN: begin
                if (cyc_q != '1) cyc_d = cyc_q + CYC_ONE;
                // Restart outranks Done; a halting cycle keeps pc and ignores the branch.
                if (start)        state_d = ARMED;
                else if (Done_in) state_d = HALT;
                else              pc_d    = next_pc;
            end
            HALT: begin
                if (start) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
    end

    // br_taken only matters through next_pc; kept as a named net for visibility.
    logic unused_taken;
    assign unused_taken = br_taken;

    assign pc          = pc_q;
    assign cycle_count = cyc_q;
    assign fetch_en    = (state_q == RUN);
    assign done        = (state_q == IDLE) || (state_q == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default-width instance and a narrow
// (PC_W=4, CYC_W=3) instance for wrap and saturation corners.
module tb_pc_sequencer;

    logic Clk;
    logic Reset;

    // Default instance (PC_W=10, CYC_W=16)
    logic        start, Zero_in, Done_in, br_en, br_rel;
    logic [1:0]  br_cond;
    logic [9:0]  br_offset, br_target, pc;
    logic        fetch_en, done;
    logic [15:0] cycle_count;

    // Narrow instance (PC_W=4, CYC_W=3)
    logic        s_start, s_zero, s_done_in, s_br_en, s_br_rel;
    logic [1:0]  s_br_cond;
    logic [3:0]  s_br_offset, s_br_target, s_pc;
    logic        s_fetch_en, s_done;
    logic [2:0]  s_cycle_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    pc_sequencer dut (
        .Clk(Clk), .Reset(Reset), .start(start), .Zero_in(Zero_in), .Done_in(Done_in),
        .br_en(br_en), .br_cond(br_cond), .br_rel(br_rel), .br_offset(br_offset),
        .br_target(br_target), .pc(pc), .fetch_en(fetch_en), .done(done),
        .cycle_count(cycle_count)
    );

    pc_sequencer #(.PC_W(4), .CYC_W(3), .RESET_PC(4'd0)) dut_s (
        .Clk(Clk), .Reset(Reset), .start(s_start), .Zero_in(s_zero), .Done_in(s_done_in),
        .br_en(s_br_en), .br_cond(s_br_cond), .br_rel(s_br_rel), .br_offset(s_br_offset),
        .br_target(s_br_target), .pc(s_pc), .fetch_en(s_fetch_en), .done(s_done),
        .cycle_count(s_cycle_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        Reset = 1'b1;
        start = 1'b0; Zero_in = 1'b0; Done_in = 1'b1;
        br_en = 1'b0; br_cond = 2'b00; br_rel = 1'b0; br_offset = '0; br_target = '0;
        s_start = 1'b0; s_zero = 1'b0; s_done_in = 1'b0;
        s_br_en = 1'b0; s_br_cond = 2'b00; s_br_rel = 1'b0; s_br_offset = '0; s_br_target = '0;
        #1;
        check_eq("rst_pc", 32'(pc), 32'd0);
        check_eq("rst_done", 32'(done), 32'd1);
        check_eq("rst_fetch", 32'(fetch_en), 32'd0);
        check_eq("rst_cc", 32'(cycle_count), 32'd0);
        tick(2);
        Reset = 1'b0;
        tick(1);
        check_eq("idle_done", 32'(done), 32'd1);

        // Arm while Flags still shows Done=1
        start = 1'b1;
        tick(1);
        check_eq("armed_done", 32'(done), 32'd0);
        check_eq("armed_fetch", 32'(fetch_en), 32'd0);
        tick(2);
        start = 1'b0; Done_in = 1'b0;
        tick(1);
        check_eq("run0_fetch", 32'(fetch_en), 32'd1);
        check_eq("run0_pc", 32'(pc), 32'd0);
        tick(4);
        check_eq("run4_pc", 32'(pc), 32'd4);
        Done_in = 1'b1;
        tick(1);
        Done_in = 1'b0;
        check_eq("halt_done", 32'(done), 32'd1);
        check_eq("halt_fetch", 32'(fetch_en), 32'd0);
        check_eq("halt_pc", 32'(pc), 32'd4);
        check_eq("halt_cc", 32'(cycle_count), 32'd5);
        tick(2);
        check_eq("halt_hold_pc", 32'(pc), 32'd4);

        // Second run from HALT
        start = 1'b1;
        tick(1);
        check_eq("rearm_done", 32'(done), 32'd0);
        start = 1'b0;
        tick(1);
        check_eq("rerun_pc", 32'(pc), 32'd0);
        check_eq("rerun_cc", 32'(cycle_count), 32'd0);
        check_eq("rerun_done", 32'(done), 32'd0);
        tick(7);
        check_eq("pc7", 32'(pc), 32'd7);

        br_en = 1'b1; br_cond = 2'b01; Zero_in = 1'b1; br_rel = 1'b0; br_target = 10'd20;
        tick(1);
        check_eq("bz_taken", 32'(pc), 32'd20);
        br_cond = 2'b00; br_target = 10'd7;
        tick(1);
        check_eq("jmp_back", 32'(pc), 32'd7);
        br_cond = 2'b01; Zero_in = 1'b0; br_target = 10'd20;
        tick(1);
        check_eq("bz_not_taken", 32'(pc), 32'd8);
        br_cond = 2'b10; br_target = 10'd100;
        tick(1);
        check_eq("bnz_taken", 32'(pc), 32'd100);
        br_cond = 2'b11; br_target = 10'd5;
        tick(1);
        check_eq("never", 32'(pc), 32'd101);
        br_cond = 2'b00; br_rel = 1'b1; br_offset = 10'h3FF;
        tick(1);
        check_eq("rel_minus1", 32'(pc), 32'd100);

        // Done and a taken branch together: halt wins, pc holds
        br_rel = 1'b0; br_target = 10'd30; Done_in = 1'b1;
        tick(1);
        br_en = 1'b0; Done_in = 1'b0;
        check_eq("done_vs_br_done", 32'(done), 32'd1);
        check_eq("done_vs_br_pc", 32'(pc), 32'd100);

        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        check_eq("run3_pc", 32'(pc), 32'd1);
        // start and Done together: restart wins
        start = 1'b1; Done_in = 1'b1;
        tick(1);
        check_eq("restart_done", 32'(done), 32'd0);
        check_eq("restart_fetch", 32'(fetch_en), 32'd0);
        start = 1'b0; Done_in = 1'b0;
        tick(1);
        check_eq("restart_pc", 32'(pc), 32'd0);
        check_eq("restart_cc", 32'(cycle_count), 32'd0);
        check_eq("restart_fetch2", 32'(fetch_en), 32'd1);

        // Narrow instance: relative wrap below zero, pc wrap, counter saturation
        check_eq("s_idle", 32'(s_done), 32'd1);
        s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        tick(1);
        check_eq("s_run_pc", 32'(s_pc), 32'd0);
        tick(2);
        check_eq("s_pc2", 32'(s_pc), 32'd2);
        s_br_en = 1'b1; s_br_cond = 2'b00; s_br_rel = 1'b1; s_br_offset = 4'b1101;
        tick(1);
        s_br_en = 1'b0;
        check_eq("s_rel_wrap", 32'(s_pc), 32'd15);
        tick(1);
        check_eq("s_pc_wrap", 32'(s_pc), 32'd0);
        check_eq("s_cc4", 32'(s_cycle_count), 32'd4);
        tick(3);
        check_eq("s_cc_sat", 32'(s_cycle_count), 32'd7);
        tick(3);
        check_eq("s_cc_hold", 32'(s_cycle_count), 32'd7);
        check_eq("s_pc_10", 32'(s_pc), 32'd6);

        // Asynchronous reset between edges
        #3;
        Reset = 1'b1;
        #1;
        check_eq("arst_done", 32'(s_done), 32'd1);
        check_eq("arst_pc", 32'(s_pc), 32'd0);
        check_eq("arst_fetch", 32'(s_fetch_en), 32'd0);
        check_eq("arst_cc", 32'(s_cycle_count), 32'd0);
        tick(1);
        Reset = 1'b0;
        tick(2);
        check_eq("arst_idle", 32'(s_done), 32'd1);
        check_eq("arst_idle_fetch", 32'(s_fetch_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Consumer side of the Flags interface: reads Zero/Done flag outputs, owns the program counter and run/halt control.
- Arms on the testbench start handshake, runs until Done is seen, then reports completion.
- Resolves conditional and relative branches against Zero.
- Sits between the top-level start/done pins, the instruction fetch path and the Flags register.

Parameters:
- PC_W, 10, program counter width in bits; PC wraps modulo 2^PC_W.
- CYC_W, 16, run-cycle counter width.
- RESET_PC, 0, PC value loaded on reset and on arming.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  level request from testbench; high arms, falling edge begins run.
- Zero_in  in  1  Zero flag from the Flags register.
- Done_in  in  1  Done flag from the Flags register.
- br_en  in  1  decoder: current instruction is a branch/jump.
- br_cond  in  2  00 always, 01 if Zero, 10 if not Zero, 11 never.
- br_rel  in  1  1: target = pc + offset; 0: target = br_target.
- br_offset  in  PC_W  signed two's-complement offset.
- br_target  in  PC_W  absolute target.
- pc  out  PC_W  current program counter.
- fetch_en  out  1  instruction at pc is executed this cycle.
- done  out  1  machine idle/finished, to testbench.
- cycle_count  out  CYC_W  RUN cycles since last arm, saturating.

Behaviour:
- Clk and Reset as listed. Reset is asynchronous, active-high.
- Reset values: state = IDLE, pc = RESET_PC, done = 1, fetch_en = 0, cycle_count = 0.
- States: IDLE, ARMED, RUN, HALT. Outputs are registered or decoded from state only; no combinational input-to-output paths.
- IDLE: done = 1, fetch_en = 0. start = 1 -> ARMED.
- ARMED: done = 0, fetch_en = 0, pc <= RESET_PC, cycle_count <= 0 every cycle. start = 0 -> RUN.
- RUN: done = 0, fetch_en = 1, cycle_count += 1 per cycle, saturating at 2^CYC_W-1. Per-cycle priority:
  1. start = 1 -> ARMED (restart; pc reloads next cycle).
  2. Done_in = 1 -> HALT; pc holds; the branch is ignored.
  3. Branch taken -> pc <= target.
  4. Otherwise pc <= pc + 1, wrapping 2^PC_W-1 -> 0.
- Branch taken = br_en AND condition per br_cond, evaluated on Zero_in in the same cycle.
- Relative target = (pc + br_offset) mod 2^PC_W; the offset is sign-interpreted, so negative offsets wrap below 0.
- HALT: done = 1, fetch_en = 0; pc and cycle_count hold for inspection. start = 1 -> ARMED.
- Latency:
  - start falling edge -> fetch_en high on the next cycle, with pc = RESET_PC.
  - Done_in high in RUN -> done high on the next cycle.
- Done_in while not in RUN is ignored. Flags holds Done = 1 out of reset; that must not prevent arming.
- Reset mid-RUN: immediate return to IDLE with reset values; no partial state survives.
- br_* inputs are ignored when not in RUN or when br_cond = 11.

Decomposition:
- Package seq_pkg holds:
  - state enum {IDLE, ARMED, RUN, HALT};
  - br_cond enum {BR_ALWAYS, BR_ZERO, BR_NZERO, BR_NEVER};
  - default PC_W/CYC_W constants.
- One combinational sub-module, next_pc_calc, takes pc, the br_* inputs and Zero_in and returns taken and next_pc.
- The FSM, saturating counter and registers stay in pc_sequencer.

Test Plan:
- Reset, start pulsed 1 for 3 cycles, then 0; no branches; Done_in raised at cycle 5 of RUN -> pc runs 0,1,2,3,4; HALT with pc = 4, done = 1, cycle_count = 5.
- In RUN at pc = 7: br_en = 1, br_cond = 01, Zero_in = 1, br_rel = 0, target = 20 -> pc = 20. Repeat with Zero_in = 0 -> pc = 8.
- PC_W = 4, pc = 2, relative branch, br_offset = -3 (4'b1101), br_cond = 00 -> pc = 15. Then no branch -> pc = 0 (wrap).
- Same cycle: Done_in = 1 and branch taken to 30 -> HALT, pc unchanged. Same cycle: start = 1 and Done_in = 1 in RUN -> ARMED, then pc = 0, cycle_count = 0.
- CYC_W = 3, run 10 cycles -> cycle_count saturates at 7. Assert Reset asynchronously mid-RUN between clock edges -> done = 1 and pc = RESET_PC immediately, state IDLE.
- From HALT, start 1 then 0 -> second run begins at pc = 0 with cycle_count = 0, done low while ARMED and RUN.
